// File: rtl/keccak_pad_buffer_pkg.sv
// Shared types and constants for the Keccak input pad buffer.
// Build option SHA3_PAD_EN selects the SHA-3 domain suffix (0x06) instead of plain Keccak (0x01).
package pkg_keccak;

  localparam int N = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    HOLD = 2'd3
  } pad_state_t;

`ifdef SHA3_PAD_EN
  localparam logic [7:0] PAD_SUFFIX = 8'h06;
`else
  localparam logic [7:0] PAD_SUFFIX = 8'h01;
`endif

  localparam logic [7:0] PAD_FINAL = 8'h80;

endpackage

// File: rtl/keccak_pad_buffer_word.sv
// Combinational pad of the final message word: keeps the valid bytes, inserts the domain
// suffix right after them, clears the rest, and marks the block end when this is the last slot.
module keccak_pad_word
  import pkg_keccak::*;
#(
  parameter int W   = N,
  parameter int LBW = $clog2(W / 8 + 1)
) (
  input  logic [W-1:0]   word,
  input  logic [LBW-1:0] last_bytes,
  input  logic           is_final_slot,
  output logic [W-1:0]   padded
);

  localparam int BPW = W / 8;

  logic [7:0] byte_s;
  logic       room_s;

  // Byte-wise substitution; a completely full word leaves no room and passes through untouched.
  always_comb begin
    padded = '0;
    byte_s = 8'h00;
    room_s = (int'(last_bytes) < BPW);
    for (int k = 0; k < BPW; k++) begin
      if (!room_s) begin
        byte_s = word[8*k +: 8];
      end else if (k < int'(last_bytes)) begin
        byte_s = word[8*k +: 8];
      end else if (k == int'(last_bytes)) begin
        byte_s = PAD_SUFFIX;
      end else begin
        byte_s = 8'h00;
      end
      if ((k == BPW - 1) && room_s && is_final_slot) begin
        padded[8*k +: 8] = byte_s | PAD_FINAL;
      end else begin
        padded[8*k +: 8] = byte_s;
      end
    end
  end

endmodule

// File: rtl/keccak_pad_buffer.sv
// Collects W-bit words into a RATE-bit block, applies pad10*1 with a domain suffix and offers
// each finished block over valid/ready. SHA3_PAD_EN (see package) selects the suffix value.
module keccak_pad_buffer
  import pkg_keccak::*;
#(
  parameter int W    = N,
  parameter int RATE = 1088
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [W-1:0]               Din,
  input  logic                       Din_valid,
  input  logic                       Last_block,
  input  logic [$clog2(W/8+1)-1:0]   Last_bytes,
  output logic                       Buffer_full,
  output logic [RATE-1:0]            Block,
  output logic                       Block_valid,
  output logic                       Block_last,
  input  logic                       Block_ready
);

  localparam int WPB = RATE / W;
  localparam int CW  = $clog2(WPB + 1);
  localparam int LBW = $clog2(W / 8 + 1);
  localparam int BPW = W / 8;

  pad_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pad_slot_q, pad_slot_d;
  logic [RATE-1:0] block_q, block_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            pend_q, pend_d;
  logic            full_q, full_d;

  logic [W-1:0]    padded_s;
  logic            at_end_s;
  logic            last_full_s;

  assign at_end_s    = (cnt_q == CW'(WPB - 1));
  assign last_full_s = (Last_bytes >= LBW'(BPW));

  keccak_pad_word #(.W(W), .LBW(LBW)) u_pad_word (
    .word          (Din),
    .last_bytes    (Last_bytes),
    .is_final_slot (at_end_s),
    .padded        (padded_s)
  );

  // Next-state and next-block computation for the fill/pad/hold sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pad_slot_d = pad_slot_q;
    block_d    = block_q;
    valid_d    = valid_q;
    last_d     = last_q;
    pend_d     = pend_q;
    if (Start) begin
      // Start from any state opens a fresh message and drops any Din this cycle.
      state_d    = FILL;
      cnt_d      = '0;
      pad_slot_d = '0;
      block_d    = '0;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      pend_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FILL: begin
          if (Din_valid) begin
            cnt_d = cnt_q + CW'(1);
            for (int i = 0; i < WPB; i++) begin
              if (i == int'(cnt_q)) begin
                block_d[i*W +: W] = Last_block ? padded_s : Din;
              end else if (Last_block && last_full_s && (i == int'(cnt_q) + 1)) begin
                block_d[i*W +: W] = {{(W-8){1'b0}}, PAD_SUFFIX};
              end else begin
                block_d[i*W +: W] = block_q[i*W +: W];
              end
            end
            if (Last_block && last_full_s && at_end_s) begin
              // No room left for padding: ship this block and pad a fresh one afterwards.
              pend_d  = 1'b1;
              state_d = HOLD;
              valid_d = 1'b1;
              last_d  = 1'b0;
            end else if (Last_block) begin
              pad_slot_d = last_full_s ? (cnt_q + CW'(1)) : cnt_q;
              state_d    = PAD;
            end else if (at_end_s) begin
              state_d = HOLD;
              valid_d = 1'b1;
              last_d  = 1'b0;
            end else begin
              state_d = FILL;
            end
          end else begin
            state_d = FILL;
          end
        end
        PAD: begin
          for (int i = 0; i < WPB; i++) begin
            if (i > int'(pad_slot_q)) begin
              block_d[i*W +: W] = '0;
            end else begin
              block_d[i*W +: W] = block_q[i*W +: W];
            end
          end
          block_d[RATE-1 -: 8] = block_d[RATE-1 -: 8] | PAD_FINAL;
          last_d  = 1'b1;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          if (Block_ready) begin
            if (last_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end else if (pend_q) begin
              block_d       = '0;
              block_d[7:0]  = PAD_SUFFIX;
              pad_slot_d    = '0;
              pend_d        = 1'b0;
              valid_d       = 1'b0;
              state_d       = PAD;
            end else begin
              state_d = FILL;
              cnt_d   = '0;
              block_d = '0;
              valid_d = 1'b0;
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          pad_slot_d = '0;
          block_d    = '0;
          valid_d    = 1'b0;
          last_d     = 1'b0;
          pend_d     = 1'b0;
        end
      endcase
    end
    full_d = (state_d != FILL);
  end

  // State, block storage and registered handshake outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pad_slot_q <= '0;
      block_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      full_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pad_slot_q <= pad_slot_d;
      block_q    <= block_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      full_q     <= full_d;
    end
  end

  assign Buffer_full = full_q;
  assign Block       = block_q;
  assign Block_valid = valid_q;
  assign Block_last  = last_q;

endmodule

// File: tb/tb_keccak_pad_buffer.sv
// Self-checking bench for keccak_pad_buffer; expected blocks come from a byte-level
// pad10*1 model of the whole message, split into RATE-sized chunks.
module tb_keccak_pad_buffer;

  localparam int W    = 64;
  localparam int RATE = 1088;
  localparam int WPB  = 17;
  localparam int BPB  = 136;
  localparam int LBW  = 4;
`ifdef SHA3_PAD_EN
  localparam logic [7:0] SUFFIX = 8'h06;
  localparam logic [7:0] COINC  = 8'h86;
`else
  localparam logic [7:0] SUFFIX = 8'h01;
  localparam logic [7:0] COINC  = 8'h81;
`endif

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic [W-1:0]    Din = '0;
  logic            Din_valid = 1'b0;
  logic            Last_block = 1'b0;
  logic [LBW-1:0]  Last_bytes = '0;
  logic            Block_ready = 1'b0;
  logic            Buffer_full;
  logic [RATE-1:0] Block;
  logic            Block_valid;
  logic            Block_last;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] msg_w [$];
  logic [7:0]   exp_q [$];

  keccak_pad_buffer #(.W(W), .RATE(RATE)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Last_block  (Last_block),
    .Last_bytes  (Last_bytes),
    .Buffer_full (Buffer_full),
    .Block       (Block),
    .Block_valid (Block_valid),
    .Block_last  (Block_last),
    .Block_ready (Block_ready)
  );

  always #5 Clock = ~Clock;

  // Message bytes, then suffix, zero fill to a rate multiple, and 0x80 ORed into the last byte.
  task automatic build_expected(input int n, input int lb);
    logic [W-1:0] w;
    int nb;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w  = msg_w[i];
      nb = (i == n - 1) ? lb : 8;
      for (int k = 0; k < nb; k++) exp_q.push_back(w[8*k +: 8]);
    end
    exp_q.push_back(SUFFIX);
    while ((exp_q.size() % BPB) != 0) exp_q.push_back(8'h00);
    exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | 8'h80;
  endtask

  function automatic logic [RATE-1:0] exp_block(input int b);
    logic [RATE-1:0] r;
    for (int k = 0; k < BPB; k++) r[8*k +: 8] = exp_q[b*BPB + k];
    return r;
  endfunction

  task automatic random_words(input int n);
    msg_w.delete();
    for (int i = 0; i < n; i++) msg_w.push_back({$urandom, $urandom});
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    Din_valid = 1'b0;
    Last_block = 1'b0;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #1;
    vectors++; if (Buffer_full !== 1'b1) begin errors++; $display("FAIL reset_full got %b want 1", Buffer_full); end
    vectors++; if (Block_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Block_valid); end
    vectors++; if (Block_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", Block_last); end
    vectors++; if (Block !== '0) begin errors++; $display("FAIL reset_block got %h want 0", Block); end
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    vectors++; if (Buffer_full !== 1'b1) begin errors++; $display("FAIL idle_full got %b want 1", Buffer_full); end
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    vectors++; if (Buffer_full !== 1'b0) begin errors++; $display("FAIL start_full got %b want 0", Buffer_full); end
  endtask

  task automatic test_spec_vector();
    pulse_start();
    Block_ready = 1'b0;
    Din = 64'hAED66CE184BE2329; Din_valid = 1'b1; Last_block = 1'b0; Last_bytes = 4'd0;
    @(negedge Clock);
    Din = 64'h00000010F1499052; Last_block = 1'b1; Last_bytes = 4'd4;
    @(negedge Clock);
    Din_valid = 1'b0; Last_block = 1'b0;
    vectors++; if (Block_valid !== 1'b0) begin errors++; $display("FAIL sv_latency1 got %b want 0", Block_valid); end
    @(negedge Clock);
    vectors++; if (Block_valid !== 1'b1) begin errors++; $display("FAIL sv_latency2 got %b want 1", Block_valid); end
    vectors++; if (Block_last !== 1'b1) begin errors++; $display("FAIL sv_last got %b want 1", Block_last); end
    vectors++; if (Block[0 +: W] !== 64'hAED66CE184BE2329) begin errors++; $display("FAIL sv_slot0 got %h want AED66CE184BE2329", Block[0 +: W]); end
    vectors++; if (Block[W +: W] !== {32'h00000001, 32'hF1499052}) begin errors++; $display("FAIL sv_slot1 got %h want 00000001F1499052", Block[W +: W]); end
    vectors++; if (Block[16*W-1 : 2*W] !== '0) begin errors++; $display("FAIL sv_slots2_15 got %h want 0", Block[16*W-1 : 2*W]); end
    vectors++; if (Block[16*W +: W] !== 64'h8000000000000000) begin errors++; $display("FAIL sv_slot16 got %h want 8000000000000000", Block[16*W +: W]); end
    Block_ready = 1'b1;
    @(negedge Clock);
    Block_ready = 1'b0;
    vectors++; if (Block_valid !== 1'b0 || Buffer_full !== 1'b1) begin errors++; $display("FAIL sv_idle got valid=%b full=%b want 0/1", Block_valid, Buffer_full); end
  endtask

  // Drives one whole message and checks every offered block against the byte model.
  task automatic run_message(input int n, input int lb, input bit rnd);
    int wi = 0;
    int bi = 0;
    int nblk;
    int budget = 0;
    logic [RATE-1:0] eb;
    build_expected(n, lb);
    nblk = exp_q.size() / BPB;
    pulse_start();
    while (bi < nblk && budget < 3000) begin
      if (Block_valid === 1'b1) begin
        eb = exp_block(bi);
        vectors++; if (Block !== eb) begin errors++; $display("FAIL msg_block n=%0d lb=%0d blk=%0d got %h want %h", n, lb, bi, Block[511:0], eb[511:0]); end
        vectors++; if (Block_last !== (bi == nblk - 1)) begin errors++; $display("FAIL msg_last n=%0d blk=%0d got %b want %b", n, bi, Block_last, (bi == nblk - 1)); end
        Block_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (Block_ready) bi++;
      end else begin
        Block_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (wi < n) begin
        Din        = msg_w[wi];
        Last_block = (wi == n - 1);
        Last_bytes = (wi == n - 1) ? LBW'(lb) : LBW'($urandom_range(0, 15));
        Din_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (Din_valid && !Buffer_full) wi++;
      end else begin
        Din        = {$urandom, $urandom};
        Din_valid  = 1'($urandom_range(0, 1));
        Last_block = 1'($urandom_range(0, 1));
        Last_bytes = LBW'($urandom_range(0, 8));
      end
      @(negedge Clock);
      budget++;
    end
    Block_ready = 1'b0; Din_valid = 1'b0; Last_block = 1'b0;
    vectors++; if (budget >= 3000) begin errors++; $display("FAIL msg_timeout n=%0d lb=%0d got %0d blocks want %0d", n, lb, bi, nblk); end
    vectors++; if (Block_valid !== 1'b0 || Buffer_full !== 1'b1) begin errors++; $display("FAIL msg_idle got valid=%b full=%b want 0/1", Block_valid, Buffer_full); end
  endtask

  task automatic test_full_last();
    random_words(17);
    run_message(17, 8, 1'b0);
  endtask

  task automatic test_coincide();
    int waited = 0;
    random_words(17);
    pulse_start();
    Block_ready = 1'b0;
    for (int i = 0; i < WPB; i++) begin
      Din = msg_w[i]; Din_valid = 1'b1; Last_block = (i == WPB - 1); Last_bytes = 4'd7;
      @(negedge Clock);
    end
    Din_valid = 1'b0; Last_block = 1'b0;
    while (Block_valid !== 1'b1 && waited < 5) begin
      @(negedge Clock);
      waited++;
    end
    vectors++; if (Block_valid !== 1'b1) begin errors++; $display("FAIL coinc_valid got %b want 1", Block_valid); end
    vectors++; if (Block[RATE-1 -: 8] !== COINC) begin errors++; $display("FAIL coinc_byte got %h want %h", Block[RATE-1 -: 8], COINC); end
    vectors++; if (Block[RATE-9 -: 56] !== msg_w[16][55:0]) begin errors++; $display("FAIL coinc_data got %h want %h", Block[RATE-9 -: 56], msg_w[16][55:0]); end
    vectors++; if (Block_last !== 1'b1) begin errors++; $display("FAIL coinc_last got %b want 1", Block_last); end
    Block_ready = 1'b1;
    @(negedge Clock);
    Block_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    logic [RATE-1:0] eb;
    random_words(17);
    for (int i = 0; i < WPB; i++) eb[i*W +: W] = msg_w[i];
    pulse_start();
    Block_ready = 1'b0;
    for (int i = 0; i < WPB; i++) begin
      Din = msg_w[i]; Din_valid = 1'b1; Last_block = 1'b0;
      @(negedge Clock);
    end
    for (int c = 0; c < 10; c++) begin
      Din = {$urandom, $urandom}; Din_valid = 1'b1;
      vectors++; if (Block_valid !== 1'b1 || Buffer_full !== 1'b1) begin errors++; $display("FAIL stall_flags c=%0d got valid=%b full=%b want 1/1", c, Block_valid, Buffer_full); end
      vectors++; if (Block !== eb) begin errors++; $display("FAIL stall_block c=%0d got %h want %h", c, Block[255:0], eb[255:0]); end
      @(negedge Clock);
    end
    Din_valid = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    vectors++; if (Block_valid !== 1'b0 || Buffer_full !== 1'b0) begin errors++; $display("FAIL stall_abort got valid=%b full=%b want 0/0", Block_valid, Buffer_full); end
    vectors++; if (Block !== '0) begin errors++; $display("FAIL stall_clear got %h want 0", Block[255:0]); end
  endtask

  task automatic test_async_reset();
    random_words(3);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      Din = msg_w[i]; Din_valid = 1'b1; Last_block = 1'b0;
      @(negedge Clock);
    end
    #2 Reset = 1'b0;
    #1;
    vectors++; if (Buffer_full !== 1'b1 || Block_valid !== 1'b0 || Block_last !== 1'b0) begin errors++; $display("FAIL areset_flags got full=%b valid=%b last=%b want 1/0/0", Buffer_full, Block_valid, Block_last); end
    vectors++; if (Block !== '0) begin errors++; $display("FAIL areset_block got %h want 0", Block[255:0]); end
    @(negedge Clock);
    Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      Din = {$urandom, $urandom}; Din_valid = 1'b1; Last_block = 1'($urandom_range(0, 1));
      @(negedge Clock);
      vectors++; if (Buffer_full !== 1'b1 || Block_valid !== 1'b0) begin errors++; $display("FAIL areset_idle c=%0d got full=%b valid=%b want 1/0", c, Buffer_full, Block_valid); end
    end
    Din_valid = 1'b0; Last_block = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    vectors++; if (Buffer_full !== 1'b0) begin errors++; $display("FAIL areset_start got %b want 0", Buffer_full); end
  endtask

  task automatic test_random();
    int n_tab [6] = '{1, 17, 18, 34, 16, 1};
    int l_tab [6] = '{0, 0, 0, 8, 8, 8};
    int n;
    int lb;
    for (int t = 0; t < 6; t++) begin
      random_words(n_tab[t]);
      run_message(n_tab[t], l_tab[t], 1'b1);
    end
    for (int t = 0; t < 20; t++) begin
      n  = $urandom_range(1, 40);
      lb = $urandom_range(0, 8);
      random_words(n);
      run_message(n, lb, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_full_last();
    test_coincide();
    test_hold_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
